mult_4bits_seq: RTL and testbench
=================================

// Module: mult_4bits_seq
// PURPOSE
// - Sequential shift-and-add multiplier that consumes the control/operand registers of the
//   Wishbone DPRAM slave and returns product plus done flag to it.
// - Operands arrive as A/B nibbles with a level-type enable.
// - Result is Y with a completion flag fim, both read back over Wishbone.
// - One partial product per clock; no combinational multiplier.
// PARAMETERS
// - N_BITS   4   operand width; product width is 2*N_BITS; iteration count is N_BITS
// PORTS
// - clk_i      in   1         single system clock, rising edge
// - rst_i      in   1         reset, asynchronous, active-low
// - A_i        in   N_BITS    multiplicand (unsigned), sampled only at start
// - B_i        in   N_BITS    multiplier (unsigned), sampled only at start
// - enable_i   in   1         level request from control register; 1 = run, 0 = release/abort
// - Y_o        out  2*N_BITS  registered product, holds last completed result
// - fim_o      out  1         registered done flag
// BEHAVIOUR
// - Interface decided: one clock clk_i; rst_i asynchronous, active-low.
// - Reset (rst_i=0, any time, incl. mid-operation):
//   - state=IDLE; Y_o=0; fim_o=0; internal acc/mcand/mplier/cnt=0.
// - FSM states IDLE, CALC, DONE:
//   - IDLE
//     - enable_i=0: stay.
//     - enable_i=1 at edge E0: capture mcand={N_BITS'0,A_i}, mplier=B_i; acc=0; cnt=0; ->CALC.
//   - CALC, each edge:
//     - if mplier[0]: acc += mcand (2*N_BITS wide, never overflows).
//     - mcand <<= 1; mplier >>= 1; cnt++.
//     - On the edge where cnt==N_BITS-1: Y_o <= final acc (including this step); fim_o <= 1; ->DONE.
//     - enable_i=0 sampled in CALC: abort ->IDLE; Y_o keeps previous value; fim_o stays 0.
//   - DONE
//     - fim_o=1; Y_o stable.
//     - Stay while enable_i=1; no restart while enable_i stays high.
//     - enable_i=0: ->IDLE; fim_o <= 0 at that edge; Y_o retained.
// - Latency: enable_i first sampled high at edge E0; accumulation at E1..E4 (N_BITS=4);
//   fim_o=1 and Y_o=A*B visible after E4. fim_o falls 1 clock after enable_i sampled low.
// - Operand changes on A_i/B_i after E0 are ignored until the next IDLE->CALC start.
// - Back-to-back: software must drop enable_i for >=1 sampled cycle between jobs.
// - Y_o changes only on the CALC->DONE edge or reset; never shows partial sums.
// - fim_o=1 implies Y_o is the product of the operands captured at the last start.
// STRUCTURE
// - Package mult_seq_pkg:
//   - typedef enum logic [1:0] {MS_IDLE, MS_CALC, MS_DONE} mult_state_t
//   - localparam function for counter width $clog2(N_BITS)
// - Sub-module: existing registrador (DATA_WIDTH=2*N_BITS) as the Y_o result register:
//   - enable_i = CALC->DONE transition; data_i = final acc.
//   - Its reset matches rst_i active-low.
// - Remainder is one FSM + datapath always_ff (async reset) and next-state always_comb.
// TESTING
// - Reset: hold rst_i=0 with enable_i=1, A=7, B=9 -> Y_o=0, fim_o=0; release -> computation starts.
// - Basic: A=3, B=5, enable_i 0->1 at E0 -> fim_o=1 after E4, Y_o=15; holds while enable_i=1.
// - Corners:
//   - A=15, B=15 -> Y_o=225.
//   - A=0, B=9 -> Y_o=0 with fim_o=1 (flag still asserted).
//   - A=9, B=0 -> Y_o=0.
// - Operand stability: start A=6, B=7, change A=1, B=1 at E2 -> Y_o=42.
// - Abort: prior Y_o=15; start A=12, B=13, drop enable_i before E3 -> IDLE, fim_o=0, Y_o=15.
// - Release/restart: after DONE (Y_o=15), drop enable_i 1 cycle -> fim_o=0, Y_o=15 retained;
//   raise with A=2, B=8 -> Y_o=16.
// - Async reset mid-CALC at E2 -> immediately Y_o=0, fim_o=0, state IDLE.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_seq_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_CALC = 2'd1,
        MS_DONE = 2'd2
    } mult_state_t;

    localparam int N_BITS_DEFAULT = 4;

    // Width of the iteration counter; at least one bit so degenerate widths stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/registrador.sv
// Generic load-enabled register with asynchronous active-low reset.
module registrador #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    // Capture data_i only when enabled; otherwise hold the stored value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_o <= '0;
        end else if (enable_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/mult_4bits_seq.sv
// Sequential shift-and-add multiplier: one partial product per clock,
// result published through a load-enabled register only when a job completes.
module mult_4bits_seq
    import mult_seq_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_BITS-1:0]     A_i,
    input  logic [N_BITS-1:0]     B_i,
    input  logic                  enable_i,
    output logic [2*N_BITS-1:0]   Y_o,
    output logic                  fim_o
);

    localparam int                CNT_W    = cnt_width(N_BITS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_BITS - 1);

    mult_state_t             state;
    mult_state_t             state_next;
    logic [2*N_BITS-1:0]     acc;
    logic [2*N_BITS-1:0]     mcand;
    logic [N_BITS-1:0]       mplier;
    logic [CNT_W-1:0]        cnt;
    logic [2*N_BITS-1:0]     acc_sum;
    logic                    load_y;

    // Next-state decode plus the accumulator sum for the current step.
    always_comb begin
        state_next = state;
        load_y     = 1'b0;
        acc_sum    = acc + (mplier[0] ? mcand : '0);
        case (state)
            MS_IDLE: begin
                if (enable_i) begin
                    state_next = MS_CALC;
                end
            end
            MS_CALC: begin
                if (!enable_i) begin
                    state_next = MS_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = MS_DONE;
                    load_y     = 1'b1;
                end
            end
            MS_DONE: begin
                if (!enable_i) begin
                    state_next = MS_IDLE;
                end
            end
            default: begin
                state_next = MS_IDLE;
            end
        endcase
    end

    // State register, operand capture, shift-and-add datapath and done flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= MS_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            fim_o  <= 1'b0;
        end else begin
            state <= state_next;
            fim_o <= (state_next == MS_DONE);
            case (state)
                MS_IDLE: begin
                    if (enable_i) begin
                        mcand  <= {{N_BITS{1'b0}}, A_i};
                        mplier <= B_i;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MS_CALC: begin
                    if (enable_i) begin
                        acc    <= acc_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    registrador #(
        .DATA_WIDTH (2*N_BITS)
    ) u_result_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (load_y),
        .data_i   (acc_sum),
        .data_o   (Y_o)
    );

endmodule

// File: tb/tb_mult_4bits_seq.sv
// Self-checking bench for mult_4bits_seq: table vectors, corner sequences
// and random jobs against a plain-arithmetic product model.
module tb_mult_4bits_seq;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] y;
    } vec_t;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] A_i;
    logic [3:0] B_i;
    logic       enable_i;
    logic [7:0] Y_o;
    logic       fim_o;

    int         total;
    int         bad;
    logic [7:0] lastY;
    vec_t       vecs[8];

    mult_4bits_seq #(.N_BITS(4)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .A_i      (A_i),
        .B_i      (B_i),
        .enable_i (enable_i),
        .Y_o      (Y_o),
        .fim_o    (fim_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doCycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic en);
        A_i      = a;
        B_i      = b;
        enable_i = en;
    endtask

    // Waits (bounded) for fim_o after enable was raised; already counts edges done.
    task automatic waitDone(input int already, input logic [7:0] expY, input string name);
        int cycles;
        cycles = already;
        while (!fim_o && cycles < 12) begin
            doCycle();
            cycles++;
            if (!fim_o) checkOutput({name, "_y_hold"}, Y_o, lastY);
        end
        checkOutput({name, "_latency"}, 8'(cycles), 8'd5);
        checkOutput({name, "_fim"}, {7'd0, fim_o}, 8'd1);
        checkOutput({name, "_y"}, Y_o, expY);
        lastY = expY;
    endtask

    task automatic runJob(input logic [3:0] a, input logic [3:0] b, input string name);
        logic [7:0] expY;
        expY = 8'(a) * 8'(b);
        applyStimulus(a, b, 1'b1);
        waitDone(0, expY, name);
        doCycle();
        checkOutput({name, "_hold_fim"}, {7'd0, fim_o}, 8'd1);
        checkOutput({name, "_hold_y"}, Y_o, expY);
        applyStimulus(4'd0, 4'd0, 1'b0);
        doCycle();
        checkOutput({name, "_rel_fim"}, {7'd0, fim_o}, 8'd0);
        checkOutput({name, "_rel_y"}, Y_o, expY);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        lastY = 8'd0;
        vecs[0] = '{a: 4'd3,  b: 4'd5,  y: 8'd15};
        vecs[1] = '{a: 4'd15, b: 4'd15, y: 8'd225};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  y: 8'd0};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  y: 8'd0};
        vecs[4] = '{a: 4'd1,  b: 4'd1,  y: 8'd1};
        vecs[5] = '{a: 4'd15, b: 4'd1,  y: 8'd15};
        vecs[6] = '{a: 4'd1,  b: 4'd15, y: 8'd15};
        vecs[7] = '{a: 4'd8,  b: 4'd8,  y: 8'd64};

        // Reset held with a pending request, then released.
        rst_i = 1'b0;
        applyStimulus(4'd7, 4'd9, 1'b1);
        doCycle();
        doCycle();
        checkOutput("reset_y", Y_o, 8'd0);
        checkOutput("reset_fim", {7'd0, fim_o}, 8'd0);
        rst_i = 1'b1;
        waitDone(0, 8'd63, "post_reset");
        applyStimulus(4'd0, 4'd0, 1'b0);
        doCycle();
        checkOutput("post_reset_rel_fim", {7'd0, fim_o}, 8'd0);

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            runJob(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_table", i), Y_o, vecs[i].y);
        end

        // Operands changed after capture are ignored.
        applyStimulus(4'd6, 4'd7, 1'b1);
        doCycle();
        doCycle();
        applyStimulus(4'd1, 4'd1, 1'b1);
        waitDone(2, 8'd42, "stable");
        applyStimulus(4'd0, 4'd0, 1'b0);
        doCycle();

        // Abort mid-calculation keeps the previous result.
        runJob(4'd3, 4'd5, "pre_abort");
        applyStimulus(4'd12, 4'd13, 1'b1);
        doCycle();
        doCycle();
        doCycle();
        applyStimulus(4'd12, 4'd13, 1'b0);
        doCycle();
        checkOutput("abort_fim", {7'd0, fim_o}, 8'd0);
        checkOutput("abort_y", Y_o, 8'd15);
        doCycle();
        doCycle();
        checkOutput("abort_fim_later", {7'd0, fim_o}, 8'd0);
        checkOutput("abort_y_later", Y_o, 8'd15);

        // Restart after abort/release.
        runJob(4'd2, 4'd8, "restart");

        // Asynchronous reset in the middle of a calculation.
        applyStimulus(4'd11, 4'd13, 1'b1);
        doCycle();
        doCycle();
        doCycle();
        #2 rst_i = 1'b0;
        #1;
        checkOutput("async_rst_y", Y_o, 8'd0);
        checkOutput("async_rst_fim", {7'd0, fim_o}, 8'd0);
        applyStimulus(4'd0, 4'd0, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        lastY = 8'd0;
        doCycle();
        runJob(4'd5, 4'd6, "after_async");

        // Random jobs against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            runJob(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
